// File: rtl/bcd_pkg.sv
// Shared types and helpers for the packed-BCD to binary converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    localparam int DIGIT_W = 4;

    // Smallest width that holds every value of the given number of decimal digits.
    function automatic int calcBw(input int digits);
        return $clog2(10 ** digits);
    endfunction

endpackage

// File: rtl/bcd_to_bin_if.sv
// Handshake bundle between a BCD source, the converter and a binary consumer.
// The out_err signal exists only when BCD_TO_BIN_ERR_EN is defined.
interface bcd_to_bin_if
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
);
    localparam int BW = calcBw(DIGITS);

    logic                        in_valid;
    logic                        in_ready;
    logic [DIGITS*DIGIT_W-1:0]   in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [BW-1:0]               out_data;
`ifdef BCD_TO_BIN_ERR_EN
    logic                        out_err;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
`endif

endinterface

// File: rtl/bcd_digit_mac.sv
// One Horner step of the decimal decode: acc*10 + digit, truncated to BW bits.
module bcd_digit_mac
    import bcd_pkg::*;
#(
    parameter int BW = 14
)(
    input  logic [BW-1:0]      i_acc,
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [BW-1:0]      o_acc,
    output logic               o_bad
);

    // acc*10 as two shifts; out-of-range digits are still used at face value.
    assign o_acc = (i_acc << 3) + (i_acc << 1) + BW'(i_digit);
    assign o_bad = (i_digit > DIGIT_W'(9));

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter, one digit per clock, MSD first.
// Defining BCD_TO_BIN_ERR_EN adds a sticky out_err flag for nibbles above 9.
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
)(
    input  logic        clk,
    input  logic        rst,
    bcd_to_bin_if.slave bus
);

    localparam int BW = calcBw(DIGITS);
    localparam int DW = DIGITS * DIGIT_W;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t        r_state;
    state_t        w_nextState;
    logic [DW-1:0] r_shift;
    logic [BW-1:0] r_acc;
    logic [BW-1:0] w_macAcc;
    logic [CW-1:0] r_cnt;
    logic          w_macBad;
    logic          w_accept;
    logic          w_inReady;
    logic          w_outValid;

    assign w_accept = (r_state == IDLE) && bus.in_valid;

    bcd_digit_mac #(.BW(BW)) u_mac (
        .i_acc   (r_acc),
        .i_digit (r_shift[DW-1 -: DIGIT_W]),
        .o_acc   (w_macAcc),
        .o_bad   (w_macBad)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_nextState = CONV;
            CONV:    if (r_cnt == '0)   w_nextState = DONE;
            DONE:    if (bus.out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_inReady  = (r_state == IDLE);
        w_outValid = (r_state == DONE);
    end

    // The accumulator doubles as the result register, so it is frozen in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_shift <= bus.in_data;
                        r_acc   <= '0;
                        r_cnt   <= CW'(DIGITS - 1);
                    end
                end
                CONV: begin
                    r_shift <= r_shift << DIGIT_W;
                    r_acc   <= w_macAcc;
                    r_cnt   <= r_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = w_outValid;
    assign bus.out_data  = r_acc;

`ifdef BCD_TO_BIN_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst)                                r_err <= 1'b0;
        else if (w_accept)                      r_err <= 1'b0;
        else if (r_state == CONV && w_macBad)   r_err <= 1'b1;
    end

    assign bus.out_err = r_err;
`else
    logic w_unusedBad;
    logic w_unusedAccept;
    assign w_unusedBad    = w_macBad;
    assign w_unusedAccept = w_accept;
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: fixed vectors, corner sequences and random words.
// Error-flag checks are compiled in only when BCD_TO_BIN_ERR_EN is defined.
module tb_bcd_to_bin;
    import bcd_pkg::*;

    localparam int DIGITS = 4;
    localparam int BW     = calcBw(DIGITS);

    typedef struct {
        string       name;
        logic [15:0] word;
        int          hold;
        bit          toggle;
        logic [31:0] expData;
        bit          expErr;
    } vec_t;

    logic clk;
    logic rst;
    int   nCompared;
    int   nMismatched;

    bcd_to_bin_if #(.DIGITS(DIGITS)) bus ();

    bcd_to_bin #(.DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
        end
    endtask

    // Reference: positional decimal weighting of each nibble, wrapped to BW bits.
    function automatic void refModel(input logic [15:0] w, output logic [31:0] val, output bit err);
        longint sum;
        longint weight;
        sum    = 0;
        weight = 1;
        err    = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            int nib;
            nib = int'((w >> (4 * i)) & 16'hF);
            sum += longint'(nib) * weight;
            weight *= 10;
            if (nib > 9) err = 1'b1;
        end
        val = 32'(sum % (longint'(1) << BW));
    endfunction

    task automatic applyStimulus(input string name, input logic [15:0] word, input int hold,
                                 input bit toggle, input logic [31:0] expData, input bit expErr);
        int guard;
        int lat;
        guard = 0;
        while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({name, ".readyBefore"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = word;
        @(negedge clk);
        lat = 1;
        checkOutput({name, ".busy"}, 32'(bus.in_ready), 32'd0);
        if (!toggle) bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 50) begin
            if (toggle) begin
                bus.in_valid = ~bus.in_valid;
                bus.in_data  = 16'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        checkOutput({name, ".latency"}, 32'(lat), 32'(DIGITS + 1));
        checkOutput({name, ".data"}, 32'(bus.out_data), expData);
`ifdef BCD_TO_BIN_ERR_EN
        checkOutput({name, ".err"}, 32'(bus.out_err), 32'(expErr));
`else
        if (expErr) ;
`endif
        // Consumer stalls: result must sit still while the source keeps trying.
        for (int c = 0; c < hold; c++) begin
            bus.in_valid = toggle;
            bus.in_data  = 16'($urandom);
            @(negedge clk);
            checkOutput({name, ".holdValid"}, 32'(bus.out_valid), 32'd1);
            checkOutput({name, ".holdData"}, 32'(bus.out_data), expData);
            checkOutput({name, ".holdInReady"}, 32'(bus.in_ready), 32'd0);
`ifdef BCD_TO_BIN_ERR_EN
            checkOutput({name, ".holdErr"}, 32'(bus.out_err), 32'(expErr));
`endif
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checkOutput({name, ".drained"}, 32'(bus.out_valid), 32'd0);
        checkOutput({name, ".readyAfter"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        vec_t        vecs[8];
        logic [15:0] word;
        logic [31:0] expVal;
        bit          expErr;
        bit          sawValid;

        nCompared     = 0;
        nMismatched   = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        vecs[0] = '{"w1234",  16'h1234, 0,  1'b0, 32'd1234, 1'b0};
        vecs[1] = '{"w9999",  16'h9999, 0,  1'b0, 32'd9999, 1'b0};
        vecs[2] = '{"w0000",  16'h0000, 0,  1'b0, 32'd0,    1'b0};
        vecs[3] = '{"w0042",  16'h0042, 10, 1'b0, 32'd42,   1'b0};
        vecs[4] = '{"w12A4",  16'h12A4, 0,  1'b0, 32'd1304, 1'b1};
        vecs[5] = '{"w0001",  16'h0001, 0,  1'b0, 32'd1,    1'b0};
        vecs[6] = '{"wFFFF",  16'hFFFF, 2,  1'b0, 32'd281,  1'b1};
        vecs[7] = '{"toggle", 16'h0815, 3,  1'b1, 32'd815,  1'b0};

        repeat (2) @(negedge clk);
        checkOutput("rst.inReady", 32'(bus.in_ready), 32'd1);
        checkOutput("rst.outValid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst.outData", 32'(bus.out_data), 32'd0);
`ifdef BCD_TO_BIN_ERR_EN
        checkOutput("rst.outErr", 32'(bus.out_err), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            applyStimulus(vecs[i].name, vecs[i].word, vecs[i].hold, vecs[i].toggle,
                          vecs[i].expData, vecs[i].expErr);

        // Reset lands in the second conversion cycle of 0x5555.
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h5555;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort.inReady", 32'(bus.in_ready), 32'd1);
        checkOutput("abort.outValid", 32'(bus.out_valid), 32'd0);
        checkOutput("abort.outData", 32'(bus.out_data), 32'd0);
        sawValid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) sawValid = 1'b1;
        end
        checkOutput("abort.noResult", 32'(sawValid), 32'd0);
        applyStimulus("afterAbort", 16'h0007, 0, 1'b0, 32'd7, 1'b0);

        for (int r = 0; r < 40; r++) begin
            if (r % 2 == 0) begin
                word = '0;
                for (int d = 0; d < DIGITS; d++)
                    word = word | (16'($urandom_range(0, 9)) << (4 * d));
            end else begin
                word = 16'($urandom);
            end
            refModel(word, expVal, expErr);
            applyStimulus($sformatf("rand%0d", r), word, int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), expVal, expErr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
